// File: rtl/edge_det_pkg.sv
// Shared types and constants for the multi-channel edge detector.
// Optional debounce is selected at compile time with EDGE_DET_DEBOUNCE_EN.
package edge_det_pkg;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'b00,
        EDGE_FALL = 2'b01,
        EDGE_BOTH = 2'b10,
        EDGE_OFF  = 2'b11
    } edge_mode_t;

    localparam int unsigned DEB_CNT_W = 8;

    // Edge qualifier shared by every channel; lvl_d is the previous-cycle level.
    function automatic logic edge_term(input edge_mode_t mode, input logic lvl, input logic lvl_d);
        logic w_t;
        w_t = 1'b0;
        case (mode)
            EDGE_RISE: w_t = lvl & ~lvl_d;
            EDGE_FALL: w_t = ~lvl & lvl_d;
            EDGE_BOTH: w_t = lvl ^ lvl_d;
            default:   w_t = 1'b0;
        endcase
        return w_t;
    endfunction

endpackage

// File: rtl/edge_det_chan.sv
// One edge-detector channel: synchronizer, optional debounce, history, pulse and sticky flag.
// Debounce counter exists only when EDGE_DET_DEBOUNCE_EN is defined.
module edge_det_chan
    import edge_det_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter bit          RESET_LEVEL     = 1'b0,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sig,
    input  edge_mode_t mode,
    input  logic       clr,
    output logic       pe,
    output logic       pend
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_param_err
        $error("edge_det_chan: SYNC_STAGES or DEBOUNCE_CYCLES out of range");
    end

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;
    logic                   w_lvl;
    logic                   r_lvl_d;
    logic                   r_pe;
    logic                   r_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sig};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

`ifdef EDGE_DET_DEBOUNCE_EN
    localparam logic [DEB_CNT_W-1:0] DEB_LAST = DEB_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [DEB_CNT_W-1:0] r_cnt;
    logic                 r_lvl;

    // Level follows s only after it has differed for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_lvl <= RESET_LEVEL;
        end else if (w_s == r_lvl) begin
            r_cnt <= '0;
        end else if (r_cnt == DEB_LAST) begin
            r_cnt <= '0;
            r_lvl <= w_s;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_lvl = r_lvl;
`else
    assign w_lvl = w_s;
`endif

    // Set wins over a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lvl_d <= RESET_LEVEL;
            r_pe    <= 1'b0;
            r_pend  <= 1'b0;
        end else begin
            r_lvl_d <= w_lvl;
            r_pe    <= edge_term(mode, w_lvl, r_lvl_d);
            if (r_pe) begin
                r_pend <= 1'b1;
            end else if (clr) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign pe   = r_pe;
    assign pend = r_pend;

endmodule

// File: rtl/edge_det_multi.sv
// Multi-channel edge detector with sticky pending flags and a registered masked interrupt.
// Define EDGE_DET_DEBOUNCE_EN to insert a per-channel debounce counter.
module edge_det_multi
    import edge_det_pkg::*;
#(
    parameter int unsigned CHANNELS        = 8,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned RESET_LEVEL     = 0,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] sig,
    input  logic [1:0]          mode,
    input  logic [CHANNELS-1:0] irq_mask,
    input  logic [CHANNELS-1:0] clr,
    output logic [CHANNELS-1:0] pe,
    output logic [CHANNELS-1:0] pend,
    output logic                irq
);

    if (CHANNELS < 1 || CHANNELS > 32) begin : g_param_err
        $error("edge_det_multi: CHANNELS out of range");
    end

    edge_mode_t w_mode;
    logic       r_irq;

    assign w_mode = edge_mode_t'(mode);

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        edge_det_chan #(
            .SYNC_STAGES     (SYNC_STAGES),
            .RESET_LEVEL     (RESET_LEVEL != 0),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .sig   (sig[gi]),
            .mode  (w_mode),
            .clr   (clr[gi]),
            .pe    (pe[gi]),
            .pend  (pend[gi])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(pend & irq_mask);
        end
    end

    assign irq = r_irq;

endmodule
